alsa_capture: RTL and testbench

Audio capture path and the write-side counterpart of the ALSA playback block. It takes stereo 16-bit PCM samples from the core, packs two stereo frames into each 64-bit word and writes those words into a DDR ring buffer through an Avalon-MM write master. It publishes a byte write pointer that the HPS driver polls to consume captured audio. It sits in sys/ beside the playback block and shares the ram_clk DDR port arbitration.

---
 rtl/alsa_capture.sv | 189 ++++++++++++++++++
 tb/tb_alsa_capture.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsa_capture.sv
// alsa_capture: packs stereo PCM frame pairs into 64-bit words and writes them to a DDR ring buffer.
// IDLE | no write outstanding          WRITE | one Avalon write held until accepted
module alsa_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVF_W      = 16
) (
  input  logic             ram_clk,
  input  logic             reset,
  input  logic [31:0]      cfg_addr,
  input  logic [31:0]      cfg_len,
  input  logic             cfg_load,
  input  logic [15:0]      pcm_l,
  input  logic [15:0]      pcm_r,
  input  logic             pcm_strobe,
  output logic [28:0]      ram_address,
  output logic [7:0]       ram_burstcount,
  output logic [63:0]      ram_writedata,
  output logic [7:0]       ram_byteenable,
  output logic             ram_write,
  input  logic             ram_waitrequest,
  output logic [31:0]      buf_wptr,
  output logic             wrap,
  output logic [OVF_W-1:0] ovf_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t           state_q, state_d;
  logic [28:0]      base_q, base_d, sh_base_q, sh_base_d, addr_q, addr_d;
  logic [31:0]      len_q, len_d, sh_len_q, sh_len_d, wptr_q, wptr_d, low_q, low_d;
  logic             sh_pend_q, sh_pend_d, half_q, half_d, wrap_q, wrap_d, write_q, write_d;
  logic [63:0]      data_q, data_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [63:0]      mem_q [FIFO_DEPTH];

  logic        accept, apply, issue, push, pop;
  logic [28:0] new_base;
  logic [31:0] new_len;
  logic [32:0] wptr_nxt;
  logic        unused_cfg_bits;

  assign unused_cfg_bits = ^{cfg_addr[2:0], cfg_len[2:0]};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    sh_base_d = sh_base_q;
    sh_len_d  = sh_len_q;
    sh_pend_d = sh_pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = write_q;
    wptr_d    = wptr_q;
    wrap_d    = 1'b0;
    low_d     = low_q;
    half_d    = half_q;
    ovf_d     = ovf_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    accept   = (state_q == WRITE) && !ram_waitrequest;
    new_base = cfg_load ? cfg_addr[31:3] : sh_base_q;
    new_len  = cfg_load ? {cfg_len[31:3], 3'b000} : sh_len_q;
    // A reconfiguration never withdraws a pending request; it lands when that write is accepted.
    apply    = (state_q == IDLE) ? cfg_load : (accept && (cfg_load || sh_pend_q));
    wptr_nxt = {1'b0, wptr_q} + 33'd8;

    if (state_q == WRITE && cfg_load && !accept) begin
      sh_pend_d = 1'b1;
      sh_base_d = cfg_addr[31:3];
      sh_len_d  = {cfg_len[31:3], 3'b000};
    end

    if (accept) begin
      state_d = IDLE;
      write_d = 1'b0;
      if (!apply) begin
        if (wptr_nxt >= {1'b0, len_q}) begin
          wptr_d = '0;
          wrap_d = 1'b1;
        end else begin
          wptr_d = wptr_nxt[31:0];
        end
      end
    end

    if (apply) begin
      base_d    = new_base;
      len_d     = new_len;
      sh_pend_d = 1'b0;
      wptr_d    = '0;
      half_d    = 1'b0;
      ovf_d     = '0;
      rd_d      = '0;
      wr_d      = '0;
      cnt_d     = '0;
    end else begin
      issue = (state_q == IDLE) && (cnt_q != '0) && (len_q != '0);
      // The head word moves into the output register at issue, freeing its FIFO slot.
      pop   = issue;
      if (issue) begin
        state_d = WRITE;
        write_d = 1'b1;
        addr_d  = base_q + wptr_q[31:3];
        data_d  = mem_q[rd_q];
      end
      if (pcm_strobe && (len_q != '0) && !cfg_load) begin
        if (!half_q) begin
          low_d  = {pcm_r, pcm_l};
          half_d = 1'b1;
        end else begin
          half_d = 1'b0;
          if ((cnt_q != CW'(FIFO_DEPTH)) || pop) begin
            push = 1'b1;
          end else if (ovf_q != '1) begin
            ovf_d = ovf_q + OVF_W'(1);
          end
        end
      end
      rd_d  = rd_q + AW'(pop);
      wr_d  = wr_q + AW'(push);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge ram_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      sh_base_q <= '0;
      sh_len_q  <= '0;
      sh_pend_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      wptr_q    <= '0;
      wrap_q    <= 1'b0;
      low_q     <= '0;
      half_q    <= 1'b0;
      ovf_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      sh_base_q <= sh_base_d;
      sh_len_q  <= sh_len_d;
      sh_pend_q <= sh_pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      wptr_q    <= wptr_d;
      wrap_q    <= wrap_d;
      low_q     <= low_d;
      half_q    <= half_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge ram_clk) begin
    if (push) mem_q[wr_q] <= {pcm_r, pcm_l, low_q};
  end

  assign ram_address    = addr_q;
  assign ram_writedata  = data_q;
  assign ram_write      = write_q;
  assign ram_burstcount = {7'd0, write_q};
  assign ram_byteenable = 8'hFF;
  assign buf_wptr       = wptr_q;
  assign wrap           = wrap_q;
  assign ovf_cnt        = ovf_q;

endmodule

// File: tb/tb_alsa_capture.sv
// Bench for alsa_capture: directed and randomized capture sequences against a queue-based model of the ring writer.
module tb_alsa_capture;
  localparam int DEPTH = 4;
  localparam int OVF_W = 16;

  logic             ram_clk = 1'b0;
  logic             reset;
  logic [31:0]      cfg_addr, cfg_len;
  logic             cfg_load;
  logic [15:0]      pcm_l, pcm_r;
  logic             pcm_strobe;
  logic [28:0]      ram_address;
  logic [7:0]       ram_burstcount;
  logic [63:0]      ram_writedata;
  logic [7:0]       ram_byteenable;
  logic             ram_write;
  logic             ram_waitrequest;
  logic [31:0]      buf_wptr;
  logic             wrap;
  logic [OVF_W-1:0] ovf_cnt;

  logic hold_w = 1'b0;
  logic rnd_w  = 1'b0;
  logic rnd_en = 1'b0;
  int   rnd_run = 0;
  assign ram_waitrequest = hold_w | rnd_w;

  alsa_capture #(.FIFO_DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .ram_clk(ram_clk), .reset(reset),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_load(cfg_load),
    .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_strobe(pcm_strobe),
    .ram_address(ram_address), .ram_burstcount(ram_burstcount),
    .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .ram_write(ram_write), .ram_waitrequest(ram_waitrequest),
    .buf_wptr(buf_wptr), .wrap(wrap), .ovf_cnt(ovf_cnt)
  );

  always #5 ram_clk = ~ram_clk;

  // Random stall generator: never stalls more than two cycles in a row.
  always @(posedge ram_clk) begin
    #1;
    if (rnd_en) begin
      if (rnd_run >= 2) rnd_w = 1'b0;
      else rnd_w = 1'($urandom_range(0, 1));
      rnd_run = rnd_w ? rnd_run + 1 : 0;
    end else begin
      rnd_w = 1'b0;
      rnd_run = 0;
    end
  end

  // Bus monitor: records every accepted write and any protocol irregularity.
  logic [28:0] acc_addr[$];
  logic [63:0] acc_data[$];
  int          wr_cycles = 0, wrap_cnt = 0, stab_bad = 0, bad_bus = 0;
  logic        prev_stall = 1'b0;
  logic [28:0] prev_addr;
  logic [63:0] prev_data;

  always @(negedge ram_clk) begin
    if (!reset) begin
      if (ram_write) begin
        wr_cycles++;
        if (ram_burstcount != 8'd1 || ram_byteenable != 8'hFF) bad_bus++;
        if (prev_stall && (ram_address != prev_addr || ram_writedata != prev_data)) stab_bad++;
        if (!ram_waitrequest) begin
          acc_addr.push_back(ram_address);
          acc_data.push_back(ram_writedata);
        end
      end else if (ram_burstcount != 8'd0) begin
        bad_bus++;
      end
      if (wrap) wrap_cnt++;
      prev_stall = ram_write && ram_waitrequest;
      prev_addr  = ram_address;
      prev_data  = ram_writedata;
    end
  end

  // Reference model: expected words with their ring addresses, in acceptance order.
  logic [28:0] exp_addr[$];
  logic [63:0] exp_data[$];
  bit          exp_wrap[$];
  logic [28:0] m_base = '0;
  logic [31:0] m_len = '0, m_wptr = '0, m_low = '0;
  bit          m_half = 1'b0;
  logic [15:0] m_ovf = '0;
  int          chk_idx = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask

  task automatic model_cfg(input logic [31:0] a, input logic [31:0] l);
    m_base = a[31:3];
    m_len  = {l[31:3], 3'b000};
    m_wptr = '0;
    m_half = 1'b0;
    m_ovf  = '0;
  endtask

  task automatic model_strobe(input logic [15:0] l, input logic [15:0] r);
    logic [28:0] a;
    if (m_len == 0) return;
    if (!m_half) begin
      m_low  = {r, l};
      m_half = 1'b1;
    end else begin
      m_half = 1'b0;
      // One word can sit in the bus register plus DEPTH in the FIFO.
      if (exp_data.size() - acc_data.size() >= DEPTH + 1) begin
        if (m_ovf != 16'hFFFF) m_ovf++;
      end else begin
        a = m_base + m_wptr[31:3];
        exp_addr.push_back(a);
        exp_data.push_back({r, l, m_low});
        m_wptr += 8;
        if (m_wptr >= m_len) begin
          m_wptr = 0;
          exp_wrap.push_back(1'b1);
        end else begin
          exp_wrap.push_back(1'b0);
        end
      end
    end
  endtask

  // Reconfiguration while a write is pending: that word survives (no advance, no wrap), later ones are flushed.
  task automatic model_cfg_mid(input logic [31:0] a, input logic [31:0] l);
    int keep;
    keep = acc_data.size() + 1;
    while (exp_data.size() > keep) begin
      void'(exp_data.pop_back());
      void'(exp_addr.pop_back());
      void'(exp_wrap.pop_back());
    end
    if (exp_wrap.size() > 0) exp_wrap[exp_wrap.size() - 1] = 1'b0;
    model_cfg(a, l);
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, input int gap);
    pcm_l = l;
    pcm_r = r;
    pcm_strobe = 1'b1;
    model_strobe(l, r);
    tick();
    pcm_strobe = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic cfg_idle(input logic [31:0] a, input logic [31:0] l);
    cfg_addr = a;
    cfg_len  = l;
    cfg_load = 1'b1;
    model_cfg(a, l);
    tick();
    cfg_load = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    int k, wsum;
    k = 0;
    while (acc_data.size() < exp_data.size() && k < 400) begin
      tick();
      k++;
    end
    repeat (4) tick();
    @(negedge ram_clk);
    chk({tag, "_count"}, 64'(acc_data.size()), 64'(exp_data.size()));
    while (chk_idx < exp_data.size() && chk_idx < acc_data.size()) begin
      chk({tag, "_addr"}, 64'(acc_addr[chk_idx]), 64'(exp_addr[chk_idx]));
      chk({tag, "_data"}, acc_data[chk_idx], exp_data[chk_idx]);
      chk_idx++;
    end
    chk_idx = exp_data.size();
    wsum = 0;
    foreach (exp_wrap[i]) wsum += int'(exp_wrap[i]);
    chk({tag, "_wptr"}, 64'(buf_wptr), 64'(m_wptr));
    chk({tag, "_ovf"}, 64'(ovf_cnt), 64'(m_ovf));
    chk({tag, "_wraps"}, 64'(wrap_cnt), 64'(wsum));
    tick();
  endtask

  initial begin
    int n0, n1, w0, np;
    logic [15:0] l1, r1, l2, r2;
    reset = 1'b1;
    cfg_addr = '0; cfg_len = '0; cfg_load = 1'b0;
    pcm_l = '0; pcm_r = '0; pcm_strobe = 1'b0;

    repeat (3) @(posedge ram_clk);
    @(negedge ram_clk);
    chk("rst_write", 64'(ram_write), 64'd0);
    chk("rst_burst", 64'(ram_burstcount), 64'd0);
    chk("rst_addr", 64'(ram_address), 64'd0);
    chk("rst_data", ram_writedata, 64'd0);
    chk("rst_wptr", 64'(buf_wptr), 64'd0);
    chk("rst_wrap", 64'(wrap), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Unconfigured: strobes must be ignored entirely.
    for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 2);
    repeat (4) tick();
    @(negedge ram_clk);
    chk("uncfg_writes", 64'(wr_cycles), 64'd0);
    chk("uncfg_ovf", 64'(ovf_cnt), 64'd0);
    tick();

    // Basic capture.
    n0 = acc_data.size();
    cfg_idle(32'h3000_0000, 32'h40);
    for (int i = 0; i < 4; i++) send(16'(2 * i + 1), 16'(2 * i + 2), 3);
    drain("basic");
    chk("basic_addr0", 64'(acc_addr[n0]), 64'h0600_0000);
    chk("basic_data0", acc_data[n0], 64'h0004_0003_0002_0001);
    chk("basic_addr1", 64'(acc_addr[n0 + 1]), 64'h0600_0001);
    chk("basic_data1", acc_data[n0 + 1], 64'h0008_0007_0006_0005);
    @(negedge ram_clk);
    chk("basic_wptr_end", 64'(buf_wptr), 64'h10);
    tick();

    // Wrap: low length bits ignored, 3-word ring.
    w0 = wrap_cnt;
    cfg_idle(32'h0100_0040, 32'h1D);
    for (int i = 0; i < 16; i++) send(16'($urandom), 16'($urandom), 3);
    drain("wrap");
    @(negedge ram_clk);
    chk("wrap_pulses", 64'(wrap_cnt - w0), 64'd2);
    chk("wrap_wptr_end", 64'(buf_wptr), 64'h10);
    tick();

    // Stall and overflow.
    cfg_idle(32'h0000_1000, 32'h100);
    n0 = acc_data.size();
    hold_w = 1'b1;
    for (int i = 0; i < 12; i++) send(16'($urandom), 16'($urandom), 1);
    repeat (3) tick();
    @(negedge ram_clk);
    chk("stall_write_held", 64'(ram_write), 64'd1);
    chk("stall_addr", 64'(ram_address), 64'h200);
    chk("stall_ovf", 64'(ovf_cnt), 64'd1);
    tick();
    hold_w = 1'b0;
    drain("stall");
    chk("stall_words", 64'(acc_data.size() - n0), 64'd5);

    // Reconfigure while a write is pending.
    cfg_idle(32'h0002_0000, 32'h40);
    hold_w = 1'b1;
    send(16'h1111, 16'h2222, 2);
    send(16'h3333, 16'h4444, 2);
    repeat (3) tick();
    n0 = acc_data.size();
    cfg_addr = 32'h0004_0008;
    cfg_len  = 32'h40;
    cfg_load = 1'b1;
    model_cfg_mid(32'h0004_0008, 32'h40);
    tick();
    cfg_load = 1'b0;
    repeat (3) tick();
    hold_w = 1'b0;
    drain("reconf_pending");
    chk("reconf_old_addr", 64'(acc_addr[n0]), 64'h4000);
    send(16'h5555, 16'h6666, 2);
    send(16'h7777, 16'h8888, 2);
    drain("reconf_next");
    chk("reconf_new_addr", 64'(acc_addr[n0 + 1]), 64'h8001);

    // Odd strobe count, then restart with a strobe in the load cycle.
    cfg_idle(32'h0000_8000, 32'h80);
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 3);
    drain("odd_first");
    cfg_addr = 32'h0000_9000;
    cfg_len  = 32'h80;
    cfg_load = 1'b1;
    pcm_l = 16'hDEAD; pcm_r = 16'hBEEF; pcm_strobe = 1'b1;
    model_cfg(32'h0000_9000, 32'h80);
    tick();
    cfg_load = 1'b0;
    pcm_strobe = 1'b0;
    repeat (2) tick();
    n1 = acc_data.size();
    l1 = 16'($urandom); r1 = 16'($urandom); l2 = 16'($urandom); r2 = 16'($urandom);
    send(l1, r1, 3);
    send(l2, r2, 3);
    drain("odd_second");
    chk("odd_words", 64'(acc_data.size() - n1), 64'd1);
    chk("odd_data", acc_data[n1], {r2, l2, r1, l1});
    chk("odd_addr", 64'(acc_addr[n1]), 64'h1200);

    // Single-word ring.
    w0 = wrap_cnt;
    cfg_idle(32'h0000_0100, 32'h8);
    for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 3);
    drain("single");
    @(negedge ram_clk);
    chk("single_wraps", 64'(wrap_cnt - w0), 64'd3);
    chk("single_wptr", 64'(buf_wptr), 64'd0);
    tick();

    // Randomized rounds with random stalls.
    rnd_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cfg_idle($urandom, 32'($urandom_range(1, 8)) * 32'd8 + 32'($urandom_range(0, 7)));
      np = $urandom_range(3, 10);
      for (int i = 0; i < 2 * np; i++) send(16'($urandom), 16'($urandom), 5);
      drain("rand");
    end
    rnd_en = 1'b0;
    repeat (3) tick();

    chk("stable_under_stall", 64'(stab_bad), 64'd0);
    chk("bus_fields", 64'(bad_bus), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
